// File: rtl/qram_qdr_burst_port.sv
`default_nettype none
// ============================================================================
// Module   : qram_qdr_burst_port
// Purpose  : Burst port between on-chip request logic and an external
//            QDR-style QRAM. Forwards a free-running clock pair and buffers
//            write beats in a FIFO. Write and read bursts are serialised at
//            one beat per DDR edge with incrementing (wrapping) addresses.
//            Read data is returned after a programmable device latency.
// Ports    : Clock/Reset       system clock, async active-high reset
//            CmdValid/CmdReady/CmdWrite/CmdAddr  burst command handshake
//            WrValid/WrReady/WrData             write beat push into FIFO
//            RdValid/RdData                     returned read beats
//            DdrClockP/DdrClockN                forwarded clock pair
//            QAddr/QWriteEn_n/QReadEn_n/QData/QDataIn  device interface
// Revision : 1.0  initial release
// ============================================================================
module qram_qdr_burst_port #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int READ_LAT   = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic              CmdWrite,
    input  logic [ADDR_W-1:0] CmdAddr,
    input  logic              WrValid,
    output logic              WrReady,
    input  logic [DATA_W-1:0] WrData,
    output logic              RdValid,
    output logic [DATA_W-1:0] RdData,
    output logic              DdrClockP,
    output logic              DdrClockN,
    output logic [ADDR_W-1:0] QAddr,
    output logic              QWriteEn_n,
    output logic              QReadEn_n,
    output logic [DATA_W-1:0] QData,
    input  logic [DATA_W-1:0] QDataIn
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_CNT     = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BURST_BEATS   = BEAT_W'(BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_WR       = 3'd2,
        ST_RD_ALIGN = 3'd3,
        ST_RD       = 3'd4,
        ST_RD_DRAIN = 3'd5
    } state_t;

    state_t state, state_next;

    logic [BEAT_W-1:0]   beat, beat_next;
    logic                cmd_take;
    logic                wr_beat;
    logic                rd_beat;
    logic [ADDR_W-1:0]   base_addr;
    logic [READ_LAT-1:0] rd_pipe;

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;

    assign fifo_full = (fifo_count == FIFO_FULL_CNT);
    assign WrReady   = !fifo_full;
    assign fifo_push = WrValid && !fifo_full;
    assign fifo_pop  = wr_beat;

    // Storage is not reset; a flush only needs the pointers and count.
    always_ff @(posedge Clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= WrData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    // Outputs are registered, so a beat is "issued" in the cycle before it
    // appears on the pins. DdrClockP low now means it is high next cycle,
    // which is where beat 0 must land.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        cmd_take   = 1'b0;
        wr_beat    = 1'b0;
        rd_beat    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                beat_next = '0;
                if (CmdValid) begin
                    cmd_take   = 1'b1;
                    state_next = CmdWrite ? ST_WR_WAIT : ST_RD_ALIGN;
                end
            end
            ST_WR_WAIT: begin
                if ((fifo_count >= BURST_CNT) && !DdrClockP) begin
                    wr_beat    = 1'b1;
                    beat_next  = beat + BEAT_W'(1);
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                if (beat == BURST_BEATS) begin
                    state_next = ST_IDLE;
                end else begin
                    wr_beat   = 1'b1;
                    beat_next = beat + BEAT_W'(1);
                end
            end
            ST_RD_ALIGN: begin
                if (!DdrClockP) begin
                    rd_beat    = 1'b1;
                    beat_next  = beat + BEAT_W'(1);
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                if (beat == BURST_BEATS) begin
                    state_next = ST_RD_DRAIN;
                end else begin
                    rd_beat   = 1'b1;
                    beat_next = beat + BEAT_W'(1);
                end
            end
            ST_RD_DRAIN: begin
                if (rd_pipe == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign CmdReady  = (state == ST_IDLE);
    assign DdrClockN = ~DdrClockP;

    // ------------------------------------------------------------------
    // Device-side datapath and read return
    // ------------------------------------------------------------------
    // rd_pipe[0] is set the cycle after a read strobe; the top stage is set
    // in the cycle QDataIn carries that beat, and is captured at its end.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            DdrClockP  <= 1'b0;
            QWriteEn_n <= 1'b1;
            QReadEn_n  <= 1'b1;
            QAddr      <= '0;
            QData      <= '0;
            base_addr  <= '0;
            rd_pipe    <= '0;
            RdValid    <= 1'b0;
            RdData     <= '0;
        end else begin
            DdrClockP  <= !DdrClockP;
            QWriteEn_n <= !wr_beat;
            QReadEn_n  <= !rd_beat;
            if (cmd_take) begin
                base_addr <= CmdAddr;
            end
            // Address arithmetic is ADDR_W wide, so it wraps within a burst.
            if (wr_beat || rd_beat) begin
                QAddr <= base_addr + ADDR_W'(beat);
            end
            if (wr_beat) begin
                QData <= fifo_mem[rd_ptr];
            end
            rd_pipe <= (rd_pipe << 1) | READ_LAT'(!QReadEn_n);
            RdValid <= rd_pipe[READ_LAT-1];
            if (rd_pipe[READ_LAT-1]) begin
                RdData <= QDataIn;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qram_qdr_burst_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_qram_qdr_burst_port
// Purpose  : Directed self-checking bench for qram_qdr_burst_port with a
//            fixed-latency device model returning addr ^ 0x55.
// Revision : 1.0  initial release
// ============================================================================
module tb_qram_qdr_burst_port;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 10;
    localparam int BURST_LEN  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int READ_LAT   = 3;

    logic              Clock    = 1'b0;
    logic              Reset    = 1'b1;
    logic              CmdValid = 1'b0;
    logic              CmdWrite = 1'b0;
    logic [ADDR_W-1:0] CmdAddr  = '0;
    logic              WrValid  = 1'b0;
    logic [DATA_W-1:0] WrData   = '0;
    logic              CmdReady;
    logic              WrReady;
    logic              RdValid;
    logic [DATA_W-1:0] RdData;
    logic              DdrClockP;
    logic              DdrClockN;
    logic [ADDR_W-1:0] QAddr;
    logic              QWriteEn_n;
    logic              QReadEn_n;
    logic [DATA_W-1:0] QData;
    logic [DATA_W-1:0] QDataIn;

    qram_qdr_burst_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .READ_LAT  (READ_LAT)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdWrite  (CmdWrite),
        .CmdAddr   (CmdAddr),
        .WrValid   (WrValid),
        .WrReady   (WrReady),
        .WrData    (WrData),
        .RdValid   (RdValid),
        .RdData    (RdData),
        .DdrClockP (DdrClockP),
        .DdrClockN (DdrClockN),
        .QAddr     (QAddr),
        .QWriteEn_n(QWriteEn_n),
        .QReadEn_n (QReadEn_n),
        .QData     (QData),
        .QDataIn   (QDataIn)
    );

    always #5 Clock = ~Clock;

    // Device model: data for the address driven in cycle C is presented
    // during cycle C + READ_LAT.
    logic [ADDR_W-1:0] dev_hist [READ_LAT];
    always @(posedge Clock) begin
        for (int i = READ_LAT - 1; i > 0; i--) begin
            dev_hist[i] <= dev_hist[i-1];
        end
        dev_hist[0] <= QAddr;
    end
    assign QDataIn = DATA_W'(dev_hist[READ_LAT-1] ^ ADDR_W'('h55));

    int   n_tests = 0;
    int   n_fail  = 0;
    logic p_model = 1'b0;   // expected forwarded-clock phase

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        p_model = Reset ? 1'b0 : ~p_model;
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        WrValid = 1'b1;
        WrData  = d;
        tick();
        WrValid = 1'b0;
    endtask

    task automatic issue_cmd(input logic wr, input logic [ADDR_W-1:0] addr);
        CmdValid = 1'b1;
        CmdWrite = wr;
        CmdAddr  = addr;
        check("cmd_ready_idle", CmdReady, 1);
        tick();
        CmdValid = 1'b0;
    endtask

    // Called in a cycle where the FSM waits with enough FIFO data; beat 0
    // follows in 1 cycle if the next phase is high, otherwise in 2.
    task automatic expect_write(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] d0);
        int exp_wait;
        int n;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        exp_wait = p_model ? 2 : 1;
        n = 0;
        while (QWriteEn_n !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        check("wr_beat0_wait", n, exp_wait);
        for (int k = 0; k < BURST_LEN; k++) begin
            a = base + ADDR_W'(k);
            d = d0 + DATA_W'(k);
            check("wr_strobe", QWriteEn_n, 0);
            check("wr_addr", QAddr, a);
            check("wr_data", QData, d);
            if (k == 0) check("wr_beat0_phase", DdrClockP, 1);
            tick();
        end
        check("wr_end_strobe", QWriteEn_n, 1);
        check("wr_end_cmdready", CmdReady, 1);
    endtask

    logic [ADDR_W-1:0] rd_addr_exp [BURST_LEN] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [DATA_W-1:0] rd_data_exp [BURST_LEN] = '{8'hAB, 8'hAA, 8'h55, 8'h54};

    initial begin
        int n;
        int exp_wait;
        int rv_cnt;
        logic exp_v;

        // ---------------- Reset ----------------
        tick(); tick(); tick();
        Reset = 1'b0;
        #1;
        check("rst_clk_p", DdrClockP, 0);
        check("rst_clk_n", DdrClockN, 1);
        check("rst_wr_strobe", QWriteEn_n, 1);
        check("rst_rd_strobe", QReadEn_n, 1);
        check("rst_cmdready", CmdReady, 1);
        check("rst_wrready", WrReady, 1);
        check("rst_rdvalid", RdValid, 0);
        check("rst_qaddr", QAddr, 0);
        check("rst_qdata", QData, 0);
        check("rst_rddata", RdData, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("clk_p_toggle", DdrClockP, (i % 2 == 0) ? 1 : 0);
            check("clk_n_inverse", DdrClockN, (i % 2 == 0) ? 0 : 1);
        end

        // ---------------- Write burst ----------------
        for (int i = 0; i < BURST_LEN; i++) push(8'hA0 + 8'(i));
        issue_cmd(1'b1, 10'h010);
        check("wr_cmdready_busy", CmdReady, 0);
        expect_write(10'h010, 8'hA0);

        // ---------------- Write stall ----------------
        push(8'hB0);
        push(8'hB1);
        issue_cmd(1'b1, 10'h020);
        for (int i = 0; i < 5; i++) begin
            check("stall_strobe", QWriteEn_n, 1);
            tick();
        end
        check("stall_strobe", QWriteEn_n, 1);
        push(8'hB2);
        check("stall_strobe", QWriteEn_n, 1);
        push(8'hB3);
        expect_write(10'h020, 8'hB0);

        // ---------------- Read with wrap ----------------
        issue_cmd(1'b0, 10'h3FE);
        exp_wait = p_model ? 2 : 1;
        n = 0;
        while (QReadEn_n !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        check("rd_beat0_wait", n, exp_wait);
        for (int c = 0; c < BURST_LEN + READ_LAT + 2; c++) begin
            if (c < BURST_LEN) begin
                check("rd_strobe", QReadEn_n, 0);
                check("rd_addr", QAddr, rd_addr_exp[c]);
                if (c == 0) check("rd_beat0_phase", DdrClockP, 1);
            end else begin
                check("rd_strobe_off", QReadEn_n, 1);
            end
            exp_v = (c >= READ_LAT + 1) && (c < READ_LAT + 1 + BURST_LEN);
            check("rd_valid", RdValid, exp_v);
            if (exp_v) check("rd_data", RdData, rd_data_exp[c-READ_LAT-1]);
            if (c == READ_LAT + BURST_LEN) check("rd_cmdready_busy", CmdReady, 0);
            if (c == READ_LAT + BURST_LEN + 1) check("rd_cmdready_back", CmdReady, 1);
            tick();
        end
        check("rd_valid_quiet", RdValid, 0);

        // ---------------- FIFO full ----------------
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check("fill_wrready", WrReady, 1);
            push(8'hC0 + 8'(i));
        end
        check("full_wrready", WrReady, 0);
        push(8'hEE);
        check("full_wrready_hold", WrReady, 0);
        issue_cmd(1'b1, 10'h100);
        expect_write(10'h100, 8'hC0);
        check("drain_wrready", WrReady, 1);
        issue_cmd(1'b1, 10'h104);
        expect_write(10'h104, 8'hC4);

        // ---------------- Reset mid-read ----------------
        issue_cmd(1'b0, 10'h040);
        n = 0;
        while (QReadEn_n !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        check("rst_rd_started", QReadEn_n, 0);
        tick();
        tick();
        check("rst_rd_beat2_addr", QAddr, 10'h042);
        Reset   = 1'b1;
        p_model = 1'b0;
        #1;
        check("midrst_rd_strobe", QReadEn_n, 1);
        check("midrst_wr_strobe", QWriteEn_n, 1);
        check("midrst_qaddr", QAddr, 0);
        check("midrst_clk_p", DdrClockP, 0);
        check("midrst_clk_n", DdrClockN, 1);
        check("midrst_rdvalid", RdValid, 0);
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check("midrst_cmdready", CmdReady, 1);
        check("midrst_wrready", WrReady, 1);
        rv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (RdValid === 1'b1) rv_cnt++;
        end
        check("midrst_no_rdvalid", rv_cnt, 0);
        check("midrst_idle", CmdReady, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
